// File: rtl/paddle_tracker.sv
// paddle_tracker: clamps paddle commands, slews the paddle per frame, recentres on link loss.
// Optional deadband via PADDLE_TRACKER_DEADBAND_EN.
module paddle_tracker #(
  parameter int SCREEN_H       = 480,
  parameter int PADDLE_H       = 64,
  parameter int STEP           = 4,
  parameter int TIMEOUT_FRAMES = 120,
  parameter int DEADBAND       = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic [9:0] i_data,
  input  logic       i_frame_start,
  output logic [9:0] o_paddle_y,
  output logic [9:0] o_target_y,
  output logic       o_link_ok,
  output logic       o_moving
);
  localparam int CW = $clog2(TIMEOUT_FRAMES + 1);
  localparam logic [9:0] YMAX = 10'(SCREEN_H - PADDLE_H);
  localparam logic [9:0] YCTR = 10'((SCREEN_H - PADDLE_H) / 2);
  localparam logic [9:0] STEP_U = 10'(STEP);
  localparam logic signed [10:0] STEP_S = 11'(STEP);
  localparam logic signed [10:0] DB = 11'(DEADBAND);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_FRAMES - 1);
`ifdef PADDLE_TRACKER_DEADBAND_EN
  localparam logic DB_EN = 1'b1;
`else
  localparam logic DB_EN = 1'b0;
`endif

  typedef enum logic {LOST, TRACK} state_t;

  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [9:0] clamped, paddle_nx, target_nx;
  logic signed [10:0] d, ad, dd, add;
  logic keep, timeout;

  always_comb begin
    clamped = (i_data > YMAX) ? YMAX : i_data;
    dd = $signed({1'b0, clamped}) - $signed({1'b0, o_target_y});
    add = dd[10] ? -dd : dd;
    keep = DB_EN && (add <= DB);
    d = $signed({1'b0, o_target_y}) - $signed({1'b0, o_paddle_y});
    ad = d[10] ? -d : d;
    paddle_nx = !i_frame_start ? o_paddle_y :
                (ad <= STEP_S)  ? o_target_y :
                !d[10]          ? o_paddle_y + STEP_U : o_paddle_y - STEP_U;
    // a command in the same cycle as the final frame keeps the link alive
    timeout = (state == TRACK) && i_frame_start && !i_valid && (cnt == LAST);
    target_nx = i_valid ? (keep ? o_target_y : clamped) : timeout ? YCTR : o_target_y;
    cnt_nx = (i_valid || timeout) ? '0 :
             (state == TRACK && i_frame_start) ? cnt + CW'(1) : cnt;
    state_nx = i_valid ? TRACK : timeout ? LOST : state;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= LOST;
      cnt        <= '0;
      o_paddle_y <= YCTR;
      o_target_y <= YCTR;
      o_link_ok  <= 1'b0;
      o_moving   <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      o_paddle_y <= paddle_nx;
      o_target_y <= target_nx;
      o_link_ok  <= (state_nx == TRACK);
      o_moving   <= (paddle_nx != target_nx);
    end
  end
endmodule

// File: tb/tb_paddle_tracker.sv
// tb_paddle_tracker: directed vectors checked against a behavioural paddle model every cycle.
module tb_paddle_tracker;
  logic       clk = 0;
  logic       rst = 0;
  logic       valid = 0;
  logic [9:0] data = '0;
  logic       frame = 0;
  logic [9:0] paddle_y, target_y;
  logic       link_ok, moving;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  int m_pad = 208, m_tgt = 208, m_link = 0, m_idle = 0;

  paddle_tracker dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_data(data),
    .i_frame_start(frame), .o_paddle_y(paddle_y), .o_target_y(target_y),
    .o_link_ok(link_ok), .o_moving(moving)
  );

  always #5 clk = ~clk;

  function automatic int iabs(input int x);
    return x < 0 ? -x : x;
  endfunction

  // model: target from last command, paddle chases target, link dies after 120 silent frames
  always @(posedge clk) begin
    int old_tgt, c;
    if (rst) begin
      m_pad = 208; m_tgt = 208; m_link = 0; m_idle = 0;
    end else begin
      old_tgt = m_tgt;
      if (frame)
        m_pad = (iabs(old_tgt - m_pad) <= 4) ? old_tgt : (old_tgt > m_pad ? m_pad + 4 : m_pad - 4);
      if (valid) begin
        c = (int'(data) > 416) ? 416 : int'(data);
`ifdef PADDLE_TRACKER_DEADBAND_EN
        if (iabs(c - m_tgt) > 2) m_tgt = c;
`else
        m_tgt = c;
`endif
        m_link = 1; m_idle = 0;
      end else if (m_link == 1 && frame) begin
        m_idle = m_idle + 1;
        if (m_idle == 120) begin
          m_link = 0; m_tgt = 208; m_idle = 0;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("model_paddle", int'(paddle_y), m_pad);
      chk("model_target", int'(target_y), m_tgt);
      chk("model_link", int'(link_ok), m_link);
      chk("model_moving", int'(moving), int'(m_pad != m_tgt));
    end
  end

  task automatic cyc(input bit v, input int d, input bit f, input bit r);
    valid = v; data = 10'(d); frame = f; rst = r;
    @(posedge clk);
    @(negedge clk);
    valid = 0; frame = 0; rst = 0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 1, 0);
  endtask

  initial begin
    @(negedge clk);
    cyc(0, 0, 0, 1);
    started = 1;
    // 1: reset then idle
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    chk("rst_paddle", int'(paddle_y), 208);
    chk("rst_target", int'(target_y), 208);
    chk("rst_link", int'(link_ok), 0);
    chk("rst_moving", int'(moving), 0);
    // 2: small move
    cyc(1, 220, 0, 0);
    chk("t2_target", int'(target_y), 220);
    chk("t2_link", int'(link_ok), 1);
    chk("t2_moving0", int'(moving), 1);
    frames(1);
    chk("t2_pad1", int'(paddle_y), 212);
    frames(1);
    chk("t2_pad2", int'(paddle_y), 216);
    chk("t2_moving2", int'(moving), 1);
    frames(1);
    chk("t2_pad3", int'(paddle_y), 220);
    chk("t2_moving3", int'(moving), 0);
    // 3: clamp and full travel
    cyc(0, 0, 0, 1);
    cyc(1, 1000, 0, 0);
    chk("t3_clamp", int'(target_y), 416);
    frames(51);
    chk("t3_pad51", int'(paddle_y), 412);
    frames(1);
    chk("t3_pad52", int'(paddle_y), 416);
    frames(2);
    chk("t3_hold", int'(paddle_y), 416);
    // 4: simultaneous command and frame
    cyc(0, 0, 0, 1);
    cyc(1, 100, 1, 0);
    chk("t4_pad", int'(paddle_y), 208);
    chk("t4_target", int'(target_y), 100);
    frames(1);
    chk("t4_pad_next", int'(paddle_y), 204);
    // 5: watchdog
    cyc(1, 100, 0, 0);
    frames(119);
    chk("t5_link_119", int'(link_ok), 1);
    frames(1);
    chk("t5_link_120", int'(link_ok), 0);
    chk("t5_target", int'(target_y), 208);
    frames(3);
    cyc(1, 300, 0, 0);
    chk("t5_relink", int'(link_ok), 1);
    // 6: reset mid-slew, frame in reset cycle ignored
    cyc(0, 0, 0, 1);
    cyc(1, 400, 0, 0);
    frames(23);
    chk("t6_pad300", int'(paddle_y), 300);
    cyc(0, 0, 1, 1);
    chk("t6_pad", int'(paddle_y), 208);
    chk("t6_target", int'(target_y), 208);
    chk("t6_link", int'(link_ok), 0);
    chk("t6_moving", int'(moving), 0);
    // deadband
    cyc(1, 208, 0, 0);
    cyc(1, 210, 0, 0);
`ifdef PADDLE_TRACKER_DEADBAND_EN
    chk("db_target", int'(target_y), 208);
`else
    chk("db_target", int'(target_y), 210);
`endif
    chk("db_link", int'(link_ok), 1);
    cyc(1, 50, 0, 0);
    cyc(1, 60, 0, 0);
    chk("b2b_target", int'(target_y), 60);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/paddle_tracker.md
Name: paddle_tracker

Overview:
- Sits directly downstream of the UART command-packet aggregator in the pong design. It consumes each valid 10-bit paddle-position command and produces the on-screen paddle Y coordinate for the renderer.
- Incoming commands set a clamped target. The displayed paddle slews toward that target by at most STEP pixels per video frame, so motion is smooth and tear-free.
- A frame-based watchdog detects loss of the command stream. On timeout it returns the paddle to screen centre.

Parameters:
- SCREEN_H, 480, visible lines.
- PADDLE_H, 64, paddle height in lines.
- STEP, 4, maximum paddle movement per frame, in lines.
- TIMEOUT_FRAMES, 120, number of frames without a command before the link is declared lost.
- DEADBAND, 2, tolerance used only when the optional deadband feature is compiled in.

Ports:
- i_clk  in  1  system clock; the only clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_valid  in  1  one-cycle strobe: i_data holds a new position command.
- i_data  in  10  requested paddle top Y.
- i_frame_start  in  1  one-cycle pulse per frame from video timing, asserted at start of vblank.
- o_paddle_y  out  10  current paddle top Y; changes only on frame boundaries.
- o_target_y  out  10  latched, clamped target.
- o_link_ok  out  1  high while commands are arriving within the timeout window.
- o_moving  out  1  high while o_paddle_y != o_target_y.

Behaviour:
- Derived constants:
  - YMAX = SCREEN_H - PADDLE_H = 416.
  - YCTR = YMAX/2 = 208.
- Reset (i_rst high at a rising edge) applies to all registers, including when asserted mid-operation:
  - state = LOST
  - o_paddle_y = YCTR, o_target_y = YCTR
  - o_link_ok = 0, o_moving = 0
  - frame counter = 0
  - All strobes arriving in the reset cycle are ignored.
- Target update:
  - On i_valid, o_target_y becomes min(i_data, YMAX) on the next edge (latency 1).
  - i_data values greater than YMAX clamp to YMAX. Values of 0 and above are valid, so there is no lower clamp.
- Slew:
  - On i_frame_start, let d = target - paddle, using the target value before this edge.
  - |d| <= STEP: paddle = target.
  - d > 0: paddle += STEP.
  - d < 0: paddle -= STEP.
  - Paddle updates on the edge following the pulse (latency 1).
  - Arithmetic uses 11-bit signed d; the result never leaves [0, YMAX].
- o_moving is registered. It reflects (paddle != target) computed from the next-state values.
- State machine (2 states):
  - LOST:
    - o_link_ok = 0.
    - On i_valid: go to TRACK, o_link_ok = 1 next cycle, counter = 0.
  - TRACK:
    - o_link_ok = 1.
    - Counter increments on each i_frame_start and clears on each i_valid.
    - When i_frame_start would bring the counter to TIMEOUT_FRAMES with no i_valid in the same cycle: go to LOST, o_target_y = YCTR, counter = 0.
- Simultaneous i_valid and i_frame_start in the same cycle:
  - The slew step uses the old target.
  - The new target is latched.
  - The counter clears; valid wins over both increment and timeout.
- Counter width: clog2(TIMEOUT_FRAMES+1) bits. It never wraps.
- No backpressure: every i_valid is accepted. Back-to-back strobes keep the last value.

Optional Feature:
- Macro: PADDLE_TRACKER_DEADBAND_EN
- Defined: at i_valid, if |clamped i_data - o_target_y| <= DEADBAND, o_target_y is unchanged. The strobe still clears the counter and still moves LOST to TRACK. This suppresses jitter from noisy controllers.
- Undefined: every i_valid updates the target as described in Behaviour. The DEADBAND parameter is unused.

Test Plan:
1. Reset, then hold idle for 3 cycles -> o_paddle_y = 208, o_target_y = 208, o_link_ok = 0, o_moving = 0.
2. i_valid with i_data = 220, then 3 frame pulses -> target 220; o_link_ok = 1; paddle 212, 216, 220; o_moving falls with the third step.
3. i_valid with i_data = 1000 -> o_target_y = 416; from 208 the paddle reaches 416 after 52 frames and stays there.
4. i_valid with i_data = 100 in the same cycle as i_frame_start, with paddle = target = 208 -> paddle stays 208 that frame; target = 100; next frame paddle = 204.
5. One i_valid, then 120 frame pulses with no commands -> on the 120th pulse: o_link_ok = 0, target = 208, paddle slews back. A new i_valid restores o_link_ok = 1 one cycle later.
6. Assert i_rst mid-slew (paddle 300, target 400) -> next edge all outputs return to reset values; a frame pulse in the reset cycle has no effect. With PADDLE_TRACKER_DEADBAND_EN and target 208, i_data = 210 -> target stays 208 and o_link_ok stays 1.
